// File: rtl/mac_pkg.sv
// Shared definitions for the MAC stream engine: controller state encoding,
// default widths and the product-to-accumulator extension helper.
package mac_pkg;

    // Default widths; each one can be overridden per instance.
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 64;
    localparam int DEF_CNT_W  = 16;

    // Widest value ext_to_acc handles. ACC_W and 2*DATA_W must not exceed it.
    localparam int EXT_MAX_W  = 128;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_e;

    // Sign- or zero-extend the low src_w bits of val to the full width.
    // The caller truncates the result to its own accumulator width.
    function automatic logic [EXT_MAX_W-1:0] ext_to_acc(
        input logic [EXT_MAX_W-1:0] val,
        input int                   src_w,
        input logic                 sign_ext
    );
        logic [EXT_MAX_W-1:0] up;
        up = val << (EXT_MAX_W - src_w);
        if (sign_ext) begin
            return $signed(up) >>> (EXT_MAX_W - src_w);
        end
        return up >> (EXT_MAX_W - src_w);
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered DATA_W x DATA_W multiplier. It is the product-register stage of
// the MAC pipeline, with a signed/unsigned select and a valid bit carried
// alongside the product.
module mac_mult_stage #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  signed_mode,
    input  logic                  op_valid,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  prod_valid,
    output logic [2*DATA_W-1:0]   prod
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod_next;

    // Widen both operands to the product width and multiply. The low PROD_W
    // bits of the product are exact in both modes, so one multiplier serves
    // signed and unsigned operands.
    always_comb begin
        a_ext     = signed_mode ? {{DATA_W{op_a[DATA_W-1]}}, op_a}
                                : {{DATA_W{1'b0}}, op_a};
        b_ext     = signed_mode ? {{DATA_W{op_b[DATA_W-1]}}, op_b}
                                : {{DATA_W{1'b0}}, op_b};
        prod_next = a_ext * b_ext;
    end

    // Product register. The valid bit follows the operand stage every cycle,
    // so bubbles pass straight through.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            prod_valid <= 1'b0;
            prod       <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // values from before the edge, whatever order the blocks run in.
            prod_valid <= op_valid;
            if (op_valid) begin
                prod <= prod_next;
            end
        end
    end

endmodule

// File: rtl/mac_stream_engine.sv
// Self-sequenced multiply-accumulate engine. It accepts `len` operand pairs
// over a valid/ready handshake, forms their dot product in a three-stage
// pipeline (operand reg -> product reg -> accumulator) and holds the result
// until the consumer takes it.
// Optional feature: define MAC_SAT_EN for a saturating accumulator and a
// sticky ovf flag. Without it the accumulator wraps and ovf is tied to 0.
module mac_stream_engine
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              signed_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              ovf
);

    localparam int PROD_W = 2 * DATA_W;

    mac_state_e          state;
    mac_state_e          next_state;
    logic [CNT_W-1:0]    remaining;
    logic                mode_signed;
    logic                take;
    logic                launch;

    logic                op_valid;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                prod_valid;
    logic [PROD_W-1:0]   prod;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    acc_next;

    // Handshake and status outputs. All of them come from registered state.
    assign in_ready  = (state == ST_RUN) && (remaining != '0);
    assign take      = in_valid && in_ready;
    assign launch    = (state == ST_IDLE) && start;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = acc;

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. RUN moves on when the last pair is taken, and DRAIN
    // waits for the operand and product stages to empty.
    always_comb begin
        // NOTE: assign a default first, so every path through the case
        // drives next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (take && (remaining == CNT_W'(1))) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!op_valid && !prod_valid) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Job setup: load the pair count and latch the arithmetic mode on start,
    // then count down one per accepted pair.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            remaining   <= '0;
            mode_signed <= 1'b0;
        end else if (launch) begin
            remaining   <= len;
            mode_signed <= signed_mode;
        end else if (take) begin
            remaining   <= remaining - CNT_W'(1);
        end
    end

    // Operand register, the first pipeline stage.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            op_valid <= take;
            if (take) begin
                op_a <= a;
                op_b <= b;
            end
        end
    end

    // Product register, the second pipeline stage.
    mac_mult_stage #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk         (clk),
        .clr_n       (clr_n),
        .signed_mode (mode_signed),
        .op_valid    (op_valid),
        .op_a        (op_a),
        .op_b        (op_b),
        .prod_valid  (prod_valid),
        .prod        (prod)
    );

    // Extend the product to the accumulator width using the latched mode.
    always_comb begin
        prod_ext = ACC_W'(ext_to_acc(EXT_MAX_W'(prod), PROD_W, mode_signed));
    end

`ifdef MAC_SAT_EN
    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_wide;
    logic           sat_hit;
    logic           ovf_q;

    // Saturating add. In signed mode an overflow shows up as two addends of
    // equal sign giving a sum of the other sign. In unsigned mode it shows up
    // as a carry out of the top bit.
    always_comb begin
        sum_wide = {1'b0, acc} + {1'b0, prod_ext};
        acc_next = sum_wide[ACC_W-1:0];
        sat_hit  = 1'b0;
        if (mode_signed) begin
            if ((acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                (sum_wide[ACC_W-1] != acc[ACC_W-1])) begin
                sat_hit  = 1'b1;
                acc_next = acc[ACC_W-1] ? SMIN : SMAX;
            end
        end else if (sum_wide[ACC_W]) begin
            sat_hit  = 1'b1;
            acc_next = '1;
        end
    end

    // Accumulator with a sticky overflow flag. Both clear when a job starts.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (launch) begin
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (prod_valid) begin
            acc   <= acc_next;
            ovf_q <= ovf_q | sat_hit;
        end
    end

    assign ovf = ovf_q;
`else
    // Wrapping add, modulo 2^ACC_W.
    always_comb begin
        acc_next = acc + prod_ext;
    end

    // Accumulator, the third pipeline stage. It is cleared when a job starts.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            acc <= '0;
        end else if (launch) begin
            acc <= '0;
        end else if (prod_valid) begin
            acc <= acc_next;
        end
    end

    assign ovf = 1'b0;
`endif

endmodule

// File: doc/mac_stream_engine.md
Name: mac_stream_engine

Overview:
- Parametrised, self-sequenced multiply-accumulate engine that computes a dot product of `len` (a, b) operand pairs.
- Supersedes the externally sequenced MAC datapath: the controller is integrated, operand input uses a valid/ready handshake, signed and unsigned modes are supported, and the result is held until the consumer accepts it.
- Sits between an operand streamer and the result/host interface of the accelerator.

Parameters:
- DATA_W, 16, operand width of a and b.
- ACC_W, 64, accumulator/result width; must be ≥ 2*DATA_W.
- CNT_W, 16, width of the pair-count (`len`) input.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr_n  in  1  asynchronous active-low reset.
- start  in  1  launch a job; sampled only in IDLE.
- len  in  CNT_W  number of pairs; captured on start.
- signed_mode  in  1  1 = two's-complement operands; captured on start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine accepts a pair this cycle.
- a  in  DATA_W  operand A.
- b  in  DATA_W  operand B.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  ACC_W  accumulated sum.
- ovf  out  1  overflow flag (see Optional Feature).

Behaviour:
- Reset (clr_n = 0, asynchronous, any state, including mid-job):
  - state → IDLE; accumulator, operand, product and count registers → 0; all pipeline valid bits → 0.
  - Outputs: in_ready = 0, busy = 0, out_valid = 0, result = 0, ovf = 0.
  - Pairs in flight are discarded.
- States:
  - IDLE: start = 1 clears the accumulator and ovf, loads the remaining count from len and latches signed_mode. Next state is RUN, or DONE if len = 0 (result = 0).
  - RUN: in_ready = (remaining ≠ 0). A pair is accepted when in_valid && in_ready; each acceptance decrements remaining. When the last pair is accepted, go to DRAIN.
  - DRAIN: in_ready = 0. Stay until both pipeline valid bits are clear, then go to DONE.
  - DONE: out_valid = 1 and result = accumulator, both held stable. On out_valid && out_ready, go to IDLE; out_valid drops the following cycle.
- start is ignored outside IDLE. in_valid is ignored when in_ready = 0.
- Pipeline, 3 stages: operand register → product register → accumulate.
  - A pair accepted at edge k is added to the accumulator at edge k+2.
  - out_valid rises at edge k+3 after the last pair is accepted.
- Throughput: one pair per cycle. Stalls (in_valid = 0) are allowed anywhere in a job; bubbles propagate through the pipeline without corrupting the sum.
- Arithmetic:
  - Product is 2*DATA_W bits, signed or unsigned per the latched mode.
  - Product is sign- or zero-extended to ACC_W before the add.
  - Without saturation, the accumulator wraps modulo 2^ACC_W.
- result is driven directly from the accumulator register (no combinational path from inputs).
- A new job may start in the cycle after DONE exits (back-to-back jobs are allowed).

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined:
  - Accumulation saturates to the maximum or minimum of ACC_W: signed range in signed mode, 0 … 2^ACC_W−1 in unsigned mode.
  - ovf is set on the first saturating add and is sticky until the next start or reset.
- Undefined:
  - Accumulation wraps.
  - ovf is tied to 0.

Decomposition:
- Shared package mac_pkg holds:
  - state encoding (IDLE, RUN, DRAIN, DONE);
  - default width constants DATA_W, ACC_W, CNT_W;
  - helper function for sign/zero extension to ACC_W.
- One sub-module, mac_mult_stage: registered DATA_W × DATA_W multiply with signed/unsigned select and a valid bit pass-through. Instantiated once.

Test Plan:
- Unsigned, len = 4, pairs (1,2), (3,4), (5,6), (7,8) streamed back-to-back → result = 100; out_valid 3 cycles after the 4th accept; busy high throughout.
- Signed mode, len = 2, pairs (−3,5), (2,−7) with one idle cycle between them → result = −29 sign-extended (0xFFFF_FFFF_FFFF_FFE3).
- Unsigned, len = 1, (0xFFFF, 0xFFFF) → result = 0xFFFE0001. Hold out_ready = 0 for 5 cycles → result and out_valid stay stable; the 6th-cycle handshake returns to IDLE.
- len = 0 with start → DONE on the next cycle with result = 0; a start pulse during RUN is ignored and the count is unchanged.
- Reset mid-job after 2 of 4 pairs → all outputs 0 immediately (asynchronous). A new job with len = 1, (2,3) → result = 6, with no residue from the aborted job.
- MAC_SAT_EN defined, ACC_W = 33, unsigned, three pairs (0xFFFF, 0xFFFF) → result = 0x1_FFFF_FFFF, ovf = 1. Without the macro → result = 0x0_FFFA_0003 (wrapped), ovf = 0.
